// File: rtl/sum_result_fifo.sv
// First-word-fall-through result FIFO behind the registered adder stage.
// The adder cannot be stalled, so an input that arrives while the FIFO is full is dropped and counted.
module sum_result_fifo #(
  parameter int W      = 12,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop;
  logic             push;
  logic             drop;

  // Output handshake: a word transfers on any cycle where out_valid and out_ready
  // are both high; out_valid/out_data never depend on out_ready or on the input side.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign pop  = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = in_valid & (!full | pop);
  assign drop = in_valid & full & !pop;

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DROP_W'(1);
        end
      end
    end
  end

endmodule
